dmem_responder: RTL

Data-memory responder serving the CPU's MEM-stage load/store requests. It sits on the far side of the pipeline's data-memory port and owns a single-port word array fronted by a small posted-write (store) buffer. Writes retire immediately into the buffer and drain to the array in idle cycles. Reads return one cycle after acceptance, and a flush sequence empties the buffer on demand.

---
 rtl/dmem_responder_pkg.sv | 14 +
 rtl/dmem_store_buffer.sv | 81 ++++++++
 rtl/dmem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared constants and FSM encodings for the data-memory responder
package dmem_responder_pkg;

    localparam int DMEM_DATA_W   = 16;
    localparam int DMEM_ADDR_W   = 8;
    localparam int DMEM_WB_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - circular posted-write buffer with youngest-match address lookup
module dmem_store_buffer #(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 8,
    parameter  int DEPTH  = 4,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic              do_push;
    logic              do_pop;
    logic [PW:0]       slot_sum;
    logic [PW-1:0]     slot;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= next_ptr(tail);
            if (do_pop)  head <= next_ptr(head);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end

    // Walk oldest to youngest so the last live match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot_sum = '0;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_sum = {1'b0, head} + (PW + 1)'(k);
            if (slot_sum >= (PW + 1)'(DEPTH)) slot_sum = slot_sum - (PW + 1)'(DEPTH);
            slot = slot_sum[PW-1:0];
            if ((CW'(k) < count) && (addr_q[slot] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[slot];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage load/store responder with posted-write buffer; DMEM_STORE_FWD_EN enables store-to-load forwarding
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int WB_DEPTH = DMEM_WB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ren,
    input  logic              wen,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rsp_valid,
    output logic              stall,
    input  logic              flush_req,
    output logic              flush_done
);

`ifdef DMEM_STORE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    localparam int CW = $clog2(WB_DEPTH + 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    dmem_state_t       st_q;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_addr_hi;
    logic              load_req;
    logic              accept;
    logic              sb_push;
    logic              sb_pop;
    logic [ADDR_W-1:0] sb_head_addr;
    logic [DATA_W-1:0] sb_head_data;
    logic [CW-1:0]     sb_count;
    logic              sb_full;
    logic              sb_empty;
    logic              sb_hit;
    logic [DATA_W-1:0] sb_hit_data;

    assign word_addr      = addr[ADDR_W-1:0];
    assign unused_addr_hi = ^addr[15:ADDR_W];
    assign load_req       = ren & ~wen;

    always_comb begin
        stall = 1'b0;
        if (st_q != ST_IDLE)
            stall = 1'b1;
        else if (wen && sb_full)
            stall = 1'b1;
        else if (load_req && sb_hit && !FWD_EN)
            stall = 1'b1;
    end

    assign accept  = (ren | wen) & ~stall;
    assign sb_push = accept & wen;
    // Any cycle without an accepted request is a drain slot, stalled ones included.
    assign sb_pop  = ~accept & ~sb_empty;

    dmem_store_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WB_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push        (sb_push),
        .push_addr   (word_addr),
        .push_data   (write_data),
        .pop         (sb_pop),
        .head_addr   (sb_head_addr),
        .head_data   (sb_head_data),
        .count       (sb_count),
        .full        (sb_full),
        .empty       (sb_empty),
        .lookup_addr (word_addr),
        .hit         (sb_hit),
        .hit_data    (sb_hit_data)
    );

    always_ff @(posedge clk) begin
        if (sb_pop && !rst) mem[sb_head_addr] <= sb_head_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= accept & load_req;
            if (accept && load_req)
                read_data <= (FWD_EN && sb_hit) ? sb_hit_data : mem[word_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (st_q)
                ST_IDLE:  if (flush_req) st_q <= ST_FLUSH;
                ST_FLUSH: if (sb_count == '0) begin
                    st_q       <= ST_DONE;
                    flush_done <= 1'b1;
                end
                ST_DONE:  st_q <= ST_IDLE;
                default:  st_q <= ST_IDLE;
            endcase
        end
    end

endmodule
